// File: rtl/rgmii_rx_clock_speed_detect.sv
// RGMII RX clock speed detector: counts rising edges of the divided RX clock
// over a fixed clk_i window and reports a debounced 10/100/1000/no-clock code.
`timescale 1ns/1ps
module rgmii_rx_clock_speed_detect #(
  parameter int WINDOW_CYCLES_P = 4096,
  parameter int THRESH_1G_P     = 154,
  parameter int THRESH_100M_P   = 26,
  parameter int THRESH_10M_P    = 2,
  parameter int CONFIRM_P       = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       rx_clk_div4_i,
  output logic [1:0] speed_o,
  output logic       speed_v_o,
  output logic       speed_change_o
);

  localparam int WIN_W   = (WINDOW_CYCLES_P > 1) ? $clog2(WINDOW_CYCLES_P) : 1;
  localparam int EDGE_W  = $clog2(WINDOW_CYCLES_P + 1);
  localparam int MATCH_W = $clog2(CONFIRM_P + 1);

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES_P - 1);
  localparam logic [WIN_W-1:0]   WIN_ONE   = WIN_W'(1);
  localparam logic [EDGE_W-1:0]  EDGE_MAX  = {EDGE_W{1'b1}};
  localparam logic [EDGE_W-1:0]  EDGE_ONE  = EDGE_W'(1);
  localparam logic [EDGE_W-1:0]  TH_1G     = EDGE_W'(THRESH_1G_P);
  localparam logic [EDGE_W-1:0]  TH_100M   = EDGE_W'(THRESH_100M_P);
  localparam logic [EDGE_W-1:0]  TH_10M    = EDGE_W'(THRESH_10M_P);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] CONFIRM_C = MATCH_W'(CONFIRM_P);

  localparam logic [1:0] SPD_10M  = 2'b00;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_1G   = 2'b10;
  localparam logic [1:0] SPD_NONE = 2'b11;

  if (!((THRESH_1G_P > THRESH_100M_P) && (THRESH_100M_P > THRESH_10M_P) && (THRESH_10M_P >= 1)))
  begin : g_bad_thresh
    $error("rgmii_rx_clock_speed_detect: thresholds must satisfy 1G > 100M > 10M >= 1");
  end

  logic                sync1_r, sync2_r, dly_r;
  logic [WIN_W-1:0]    win_cnt_r;
  logic [EDGE_W-1:0]   edge_cnt_r;
  logic [1:0]          cand_r;
  logic [MATCH_W-1:0]  match_r;
  logic [1:0]          speed_r;
  logic                speed_v_r;
  logic                speed_change_r;

  logic                edge_s;
  logic                eow_s;
  logic [EDGE_W-1:0]   edge_total_s;
  logic [1:0]          class_s;
  logic [MATCH_W-1:0]  match_next_s;
  logic                commit_s;

  // Edge detect, window end, and edge total including the current-cycle edge.
  always_comb begin
    edge_s = sync2_r & ~dly_r;
    eow_s  = (win_cnt_r == WIN_LAST);
    if (edge_s && (edge_cnt_r != EDGE_MAX)) begin
      edge_total_s = edge_cnt_r + EDGE_ONE;
    end else begin
      edge_total_s = edge_cnt_r;
    end
  end

  // Classification, debounce match count and commit decision.
  always_comb begin
    if (edge_total_s >= TH_1G) begin
      class_s = SPD_1G;
    end else if (edge_total_s >= TH_100M) begin
      class_s = SPD_100M;
    end else if (edge_total_s >= TH_10M) begin
      class_s = SPD_10M;
    end else begin
      class_s = SPD_NONE;
    end
    if (class_s != cand_r) begin
      match_next_s = MATCH_ONE;
    end else if (match_r != CONFIRM_C) begin
      match_next_s = match_r + MATCH_ONE;
    end else begin
      match_next_s = match_r;
    end
    commit_s = eow_s && (match_next_s == CONFIRM_C) && (class_s != speed_r);
  end

  // Two-flop synchronizer plus delay flop for the asynchronous toggle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dly_r   <= 1'b0;
    end else begin
      sync1_r <= rx_clk_div4_i;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
    end
  end

  // Free-running window counter and per-window edge counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_cnt_r  <= {WIN_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
    end else if (eow_s) begin
      win_cnt_r  <= {WIN_W{1'b0}};
      edge_cnt_r <= {EDGE_W{1'b0}};
    end else begin
      win_cnt_r  <= win_cnt_r + WIN_ONE;
      edge_cnt_r <= edge_total_s;
    end
  end

  // Debounce state and registered outputs, updated only at window end.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cand_r         <= SPD_NONE;
      match_r        <= {MATCH_W{1'b0}};
      speed_r        <= SPD_NONE;
      speed_v_r      <= 1'b0;
      speed_change_r <= 1'b0;
    end else begin
      speed_change_r <= commit_s;
      if (eow_s) begin
        cand_r  <= class_s;
        match_r <= match_next_s;
      end
      if (commit_s) begin
        speed_r   <= class_s;
        speed_v_r <= (class_s != SPD_NONE);
      end
    end
  end

  assign speed_o        = speed_r;
  assign speed_v_o      = speed_v_r;
  assign speed_change_o = speed_change_r;

endmodule

// File: tb/tb_rgmii_rx_clock_speed_detect.sv
// Bench for rgmii_rx_clock_speed_detect: randomized toggle stimulus against a
// window-level reference model built from recorded per-cycle input samples.
`timescale 1ns/1ps
module tb_rgmii_rx_clock_speed_detect;

  localparam int W    = 4096;
  localparam int T1G  = 154;
  localparam int T100 = 26;
  localparam int T10  = 2;
  localparam int CONF = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [1:0] speed;
  logic       speed_v;
  logic       speed_chg;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc;
  int         pulses;
  bit         smp[$];
  logic [1:0] cls[$];
  logic [1:0] exp_speed;
  logic       exp_chg;
  int         ph;
  int         off;
  int         off2;

  rgmii_rx_clock_speed_detect #(
    .WINDOW_CYCLES_P(W), .THRESH_1G_P(T1G), .THRESH_100M_P(T100),
    .THRESH_10M_P(T10), .CONFIRM_P(CONF)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .rx_clk_div4_i(rx),
    .speed_o(speed), .speed_v_o(speed_v), .speed_change_o(speed_chg)
  );

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_model();
    smp.delete();
    cls.delete();
    cyc       = 0;
    exp_speed = 2'b11;
    exp_chg   = 1'b0;
  endtask

  function automatic logic [1:0] classify(input int n);
    if (n >= T1G)       return 2'b10;
    else if (n >= T100) return 2'b01;
    else if (n >= T10)  return 2'b00;
    else                return 2'b11;
  endfunction

  // A rising input sample s reaches the counter 2 cycles later, so window
  // cycles [cyc-W+1, cyc] own samples [cyc-W-1, cyc-2].
  task automatic model_eow();
    int         n;
    bit         same;
    logic [1:0] k;
    n = 0;
    for (int s = cyc - W - 1; s <= cyc - 2; s++) begin
      if (s >= 0 && smp[s] && (s == 0 || !smp[s-1])) n++;
    end
    k = classify(n);
    cls.push_back(k);
    exp_chg = 1'b0;
    if (cls.size() >= CONF) begin
      same = 1'b1;
      for (int i = 1; i <= CONF; i++) begin
        if (cls[cls.size()-i] != k) same = 1'b0;
      end
      if (same && k != exp_speed) begin
        exp_speed = k;
        exp_chg   = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v);
    rx = v;
    @(posedge clk);
    #1;
    smp.push_back(v);
    if (cyc % W == W - 1) model_eow();
    else exp_chg = 1'b0;
    check("speed", {6'b0, speed}, {6'b0, exp_speed});
    check("valid", {7'b0, speed_v}, {7'b0, (exp_speed != 2'b11)});
    check("change", {7'b0, speed_chg}, {7'b0, exp_chg});
    if (speed_chg === 1'b1) pulses++;
    cyc++;
    @(negedge clk);
  endtask

  // p == 0 freezes the input at its current level.
  task automatic run_until(input int target, input int p, input int phase);
    bit v;
    while (cyc < target) begin
      if (p == 0) v = (rx === 1'b1);
      else        v = (((cyc + phase) % p) < (p / 2));
      step(v);
    end
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #0.5;
    check("rst_speed", {6'b0, speed}, 8'h03);
    check("rst_valid", {7'b0, speed_v}, 8'h00);
    check("rst_change", {7'b0, speed_chg}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
  endtask

  function automatic bit g_pat(input int s);
    if (s >= 100 && s < 120)       return 1'b1;
    if (s >= W - 3 && s < W + 10)  return 1'b1;
    if (s >= W + 200 && s < W + 2700 && ((s - W - 200) % 100) < 20) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    reset_n = 1'b0;
    rx      = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("init_speed", {6'b0, speed}, 8'h03);
    check("init_valid", {7'b0, speed_v}, 8'h00);
    check("init_change", {7'b0, speed_chg}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();

    // Input held low for 5 windows.
    pulses = 0;
    run_until(5 * W, 0, 0);
    check("idle_pulses", 8'(pulses), 8'd0);
    check("idle_speed", {6'b0, speed}, 8'h03);

    // 1G from reset, then a single 100M glitch window.
    do_reset();
    pulses = 0;
    ph = int'($urandom_range(0, 15));
    run_until(2 * W - 1, 16, ph);
    check("1g_before_commit", {6'b0, speed}, 8'h03);
    run_until(2 * W, 16, ph);
    check("1g_commit_speed", {6'b0, speed}, 8'h02);
    check("1g_commit_pulse", {7'b0, speed_chg}, 8'h01);
    check("1g_commit_valid", {7'b0, speed_v}, 8'h01);
    run_until(2 * W - 2 + W - W, 16, ph);
    run_until(2 * W - 2, 16, ph);
    off = int'($urandom_range(0, 79));
    run_until(3 * W - 2, 80, off);
    run_until(5 * W, 16, ph);
    check("glitch_speed", {6'b0, speed}, 8'h02);
    check("glitch_pulses", 8'(pulses), 8'd1);

    // Loss of clock from 1G lock.
    pulses = 0;
    run_until(7 * W, 0, 0);
    check("loss_speed", {6'b0, speed}, 8'h03);
    check("loss_valid", {7'b0, speed_v}, 8'h00);
    check("loss_pulses", 8'(pulses), 8'd1);

    // 100M acquired mid-window, then 10M.
    pulses = 0;
    off  = int'($urandom_range(0, W / 2 - 1));
    off2 = int'($urandom_range(W / 2, W - 3));
    run_until(7 * W + off, 0, 0);
    ph = int'($urandom_range(0, 79));
    run_until(10 * W + off2, 80, ph);
    check("100m_speed", {6'b0, speed}, 8'h01);
    check("100m_pulses", 8'(pulses), 8'd1);
    pulses = 0;
    ph = int'($urandom_range(0, 799));
    run_until(13 * W, 800, ph);
    check("10m_speed", {6'b0, speed}, 8'h00);
    check("10m_valid", {7'b0, speed_v}, 8'h01);
    check("10m_pulses", 8'(pulses), 8'd1);

    // Reset at window cycle 2000, then an edge landing on the eow cycle.
    run_until(13 * W + 2000, 800, ph);
    check("mid_pre_speed", {6'b0, speed}, 8'h00);
    do_reset();
    pulses = 0;
    while (cyc < 2 * W) step(g_pat(cyc));
    check("eow_edge_speed", {6'b0, speed}, 8'h00);
    check("eow_edge_pulses", 8'(pulses), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
